// File: rtl/int_req_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// int_pkg : shared definitions for the interrupt request controller.
//   - state_t          : controller FSM encoding (3 bits)
//   - CP0_REG_*        : coprocessor-0 register indices touched by the block
//   - DEF_CAUSE_BASE   : default cause code reported for interrupt line 0
//   - DEF_ISR_BASE     : default handler entry address
// ---------------------------------------------------------------------------
package int_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        VECTOR  = 3'd2,
        ISR     = 3'd3,
        RESTORE = 3'd4
    } state_t;

    // CP0 register indices: enable, status, cause, EPC
    localparam int unsigned CP0_REG_IEN    = 11;
    localparam int unsigned CP0_REG_STATUS = 12;
    localparam int unsigned CP0_REG_CAUSE  = 13;
    localparam int unsigned CP0_REG_EPC    = 14;

    localparam logic [4:0]  DEF_CAUSE_BASE = 5'd16;
    localparam logic [31:0] DEF_ISR_BASE   = 32'h0000_0004;

endpackage

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc : fixed-priority encoder, lowest index wins.
//   req   in  NUM_IRQ  request vector
//   idx   out IW       index of the lowest set bit (0 when none set)
//   valid out 1        at least one request bit set
// ---------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int NUM_IRQ = 8,
    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/int_req_ctrl.sv
// ---------------------------------------------------------------------------
// int_req_ctrl : interrupt request controller, CP0 write initiator.
//   Latches rising edges of device interrupt lines, takes the lowest pending
//   line at an instruction boundary when enabled, writes EPC/Cause/enable to
//   CP0, redirects the PC to the handler, and on eret restores the enable and
//   returns to the EPC.
//
// Ports:
//   clk, rst (async, active low)
//   irq[NUM_IRQ]       level device requests (edge captured)
//   int_en             global enable from CP0
//   instr_boundary     CPU commit point; pc_i valid with it
//   epc_i              current CP0 EPC
//   eret               one-cycle eret pulse
//   WriteEPC/pc_save, WriteCause/InTcause, WriteIen/Int_en : CP0 writes
//   pc_redirect/redirect_pc : one-cycle PC override
//   irq_ack            one-hot acknowledge of the serviced line
//   busy               controller not idle
//
// Build option: IRQ_SYNC_EN adds a two-flop synchronizer on each irq bit.
// ---------------------------------------------------------------------------
module int_req_ctrl
    import int_pkg::*;
#(
    parameter int          NUM_IRQ    = 8,
    parameter logic [4:0]  CAUSE_BASE = DEF_CAUSE_BASE,
    parameter logic [31:0] ISR_BASE   = DEF_ISR_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               int_en,
    input  logic               instr_boundary,
    input  logic [31:0]        pc_i,
    input  logic [31:0]        epc_i,
    input  logic               eret,
    output logic               WriteEPC,
    output logic [31:0]        pc_save,
    output logic               WriteCause,
    output logic [4:0]         InTcause,
    output logic               WriteIen,
    output logic               Int_en,
    output logic               pc_redirect,
    output logic [31:0]        redirect_pc,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               busy
);

    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    // ---------------- irq sampling and edge capture ----------------
    logic [NUM_IRQ-1:0] irq_s;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_reg, sync2_reg;
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1_reg[gi] <= 1'b0;
                sync2_reg[gi] <= 1'b0;
            end else begin
                sync1_reg[gi] <= irq[gi];
                sync2_reg[gi] <= sync1_reg[gi];
            end
        end
    end
    assign irq_s = sync2_reg;
`else
    assign irq_s = irq;
`endif

    logic [NUM_IRQ-1:0] irq_q_reg, pending_reg, pending_next;
    logic [NUM_IRQ-1:0] irq_ack_reg, irq_ack_next;

    // A new edge in the acknowledge cycle wins over the clear.
    assign pending_next = (pending_reg & ~irq_ack_reg) | (irq_s & ~irq_q_reg);

    logic [IW-1:0] enc_idx;
    logic          enc_valid;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req   (pending_reg),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // ---------------- FSM ----------------
    state_t        state_reg, state_next;
    logic [IW-1:0] win_idx_reg, win_idx_next;
    logic [31:0]   pc_hold_reg, pc_hold_next;
    logic [31:0]   epc_hold_reg, epc_hold_next;
    logic          eret_sticky_reg, eret_sticky_next;
    logic [31:0]   restore_pc;

    logic          write_epc_reg, write_epc_next;
    logic [31:0]   pc_save_reg, pc_save_next;
    logic          write_cause_reg, write_cause_next;
    logic [4:0]    cause_reg, cause_next;
    logic          write_ien_reg, write_ien_next;
    logic          ien_val_reg, ien_val_next;
    logic          redirect_reg, redirect_next;
    logic [31:0]   redirect_pc_reg, redirect_pc_next;
    logic          busy_reg, busy_next;

    always_comb begin
        state_next       = state_reg;
        win_idx_next     = win_idx_reg;
        pc_hold_next     = pc_hold_reg;
        epc_hold_next    = epc_hold_reg;
        eret_sticky_next = eret_sticky_reg;
        restore_pc       = '0;

        case (state_reg)
            IDLE: begin
                if (int_en && enc_valid && instr_boundary) begin
                    state_next   = SAVE;
                    win_idx_next = enc_idx;
                    pc_hold_next = pc_i;
                end
            end
            SAVE, VECTOR: begin
                // An early eret is remembered along with the EPC seen with it.
                if (eret) begin
                    eret_sticky_next = 1'b1;
                    epc_hold_next    = epc_i;
                end
                state_next = (state_reg == SAVE) ? VECTOR : ISR;
            end
            ISR: begin
                if (eret) begin
                    state_next       = RESTORE;
                    restore_pc       = epc_i;
                    eret_sticky_next = 1'b0;
                end else if (eret_sticky_reg) begin
                    state_next       = RESTORE;
                    restore_pc       = epc_hold_reg;
                    eret_sticky_next = 1'b0;
                end
            end
            RESTORE: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so they
        // line up exactly with the state they belong to.
        write_epc_next   = 1'b0;
        pc_save_next     = '0;
        write_cause_next = 1'b0;
        cause_next       = '0;
        write_ien_next   = 1'b0;
        ien_val_next     = 1'b0;
        redirect_next    = 1'b0;
        redirect_pc_next = '0;
        irq_ack_next     = '0;
        busy_next        = (state_next != IDLE);

        case (state_next)
            SAVE: begin
                write_epc_next   = 1'b1;
                pc_save_next     = pc_hold_next;
                write_cause_next = 1'b1;
                cause_next       = CAUSE_BASE + 5'(win_idx_next);
                write_ien_next   = 1'b1;
                irq_ack_next     = NUM_IRQ'(1) << win_idx_next;
            end
            VECTOR: begin
                redirect_next    = 1'b1;
                redirect_pc_next = ISR_BASE;
            end
            RESTORE: begin
                write_ien_next   = 1'b1;
                ien_val_next     = 1'b1;
                redirect_next    = 1'b1;
                redirect_pc_next = restore_pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q_reg       <= '0;
            pending_reg     <= '0;
            state_reg       <= IDLE;
            win_idx_reg     <= '0;
            pc_hold_reg     <= '0;
            epc_hold_reg    <= '0;
            eret_sticky_reg <= 1'b0;
            write_epc_reg   <= 1'b0;
            pc_save_reg     <= '0;
            write_cause_reg <= 1'b0;
            cause_reg       <= '0;
            write_ien_reg   <= 1'b0;
            ien_val_reg     <= 1'b0;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
            irq_ack_reg     <= '0;
            busy_reg        <= 1'b0;
        end else begin
            irq_q_reg       <= irq_s;
            pending_reg     <= pending_next;
            state_reg       <= state_next;
            win_idx_reg     <= win_idx_next;
            pc_hold_reg     <= pc_hold_next;
            epc_hold_reg    <= epc_hold_next;
            eret_sticky_reg <= eret_sticky_next;
            write_epc_reg   <= write_epc_next;
            pc_save_reg     <= pc_save_next;
            write_cause_reg <= write_cause_next;
            cause_reg       <= cause_next;
            write_ien_reg   <= write_ien_next;
            ien_val_reg     <= ien_val_next;
            redirect_reg    <= redirect_next;
            redirect_pc_reg <= redirect_pc_next;
            irq_ack_reg     <= irq_ack_next;
            busy_reg        <= busy_next;
        end
    end

    assign WriteEPC    = write_epc_reg;
    assign pc_save     = pc_save_reg;
    assign WriteCause  = write_cause_reg;
    assign InTcause    = cause_reg;
    assign WriteIen    = write_ien_reg;
    assign Int_en      = ien_val_reg;
    assign pc_redirect = redirect_reg;
    assign redirect_pc = redirect_pc_reg;
    assign irq_ack     = irq_ack_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_int_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_int_req_ctrl : self-checking bench for int_req_ctrl (default build).
// The reference model tracks pending requests as a plain bit set updated on
// rising irq edges and cleared when a line is serviced; the expected serviced
// line is the lowest set bit, cause = 16 + line.
// ---------------------------------------------------------------------------
module tb_int_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq = '0;
    logic        int_en = 1'b0;
    logic        instr_boundary = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] epc_i = '0;
    logic        eret = 1'b0;

    logic        WriteEPC, WriteCause, WriteIen, ien_val, pc_redirect, busy;
    logic [31:0] pc_save, redirect_pc;
    logic [4:0]  InTcause;
    logic [7:0]  irq_ack;
    logic [5:0]  flags;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_pend = '0;
    logic [7:0] m_prev = '0;
    logic [7:0] m_clr  = '0;

    always #5 clk = ~clk;

    int_req_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .irq            (irq),
        .int_en         (int_en),
        .instr_boundary (instr_boundary),
        .pc_i           (pc_i),
        .epc_i          (epc_i),
        .eret           (eret),
        .WriteEPC       (WriteEPC),
        .pc_save        (pc_save),
        .WriteCause     (WriteCause),
        .InTcause       (InTcause),
        .WriteIen       (WriteIen),
        .Int_en         (ien_val),
        .pc_redirect    (pc_redirect),
        .redirect_pc    (redirect_pc),
        .irq_ack        (irq_ack),
        .busy           (busy)
    );

    // {WriteEPC, WriteCause, WriteIen, Int_en, pc_redirect, busy}
    assign flags = {WriteEPC, WriteCause, WriteIen, ien_val, pc_redirect, busy};

    function automatic int lowest(input logic [7:0] p);
        for (int i = 0; i < 8; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step;
        @(posedge clk);
        #1;
        m_pend = (m_pend & ~m_clr) | (irq & ~m_prev);
        m_prev = irq;
        m_clr  = '0;
    endtask

    // Take one interrupt from IDLE through RESTORE, checking every phase.
    task automatic run_service(input string tag, input logic [31:0] pc,
                               input logic [31:0] epc, input logic [7:0] toggle,
                               input bit early, output logic [4:0] cause_seen);
        int         w;
        logic [4:0] exp_cause;
        logic [7:0] exp_ack;
        w         = lowest(m_pend);
        exp_cause = 5'(16 + w);
        exp_ack   = 8'(1) << w;

        instr_boundary = 1'b1; pc_i = pc;
        step;
        instr_boundary = 1'b0; pc_i = $urandom;
        cause_seen = InTcause;
        checks++; if (flags !== 6'b111001) begin errors++; $display("FAIL %s save_flags got=%b exp=%b", tag, flags, 6'b111001); end
        checks++; if (pc_save !== pc) begin errors++; $display("FAIL %s pc_save got=%h exp=%h", tag, pc_save, pc); end
        checks++; if (InTcause !== exp_cause) begin errors++; $display("FAIL %s cause got=%0d exp=%0d", tag, InTcause, exp_cause); end
        checks++; if (irq_ack !== exp_ack) begin errors++; $display("FAIL %s irq_ack got=%b exp=%b", tag, irq_ack, exp_ack); end
        m_clr = exp_ack;

        if (early) begin eret = 1'b1; epc_i = epc; end
        step;
        eret = 1'b0; epc_i = $urandom;
        checks++; if (flags !== 6'b000011 || redirect_pc !== 32'h4 || irq_ack !== 8'h0) begin errors++; $display("FAIL %s vector got=%b/%h exp=000011/00000004", tag, flags, redirect_pc); end

        step;
        checks++; if (flags !== 6'b000001 || irq_ack !== 8'h0) begin errors++; $display("FAIL %s isr_flags got=%b exp=000001", tag, flags); end

        if (!early) begin
            if (toggle != 0) begin
                instr_boundary = 1'b1;
                irq = irq & ~toggle;
                step;
                irq = irq | toggle;
                step;
                instr_boundary = 1'b0;
                checks++; if (flags !== 6'b000001) begin errors++; $display("FAIL %s isr_hold got=%b exp=000001", tag, flags); end
            end
            epc_i = epc; eret = 1'b1;
            step;
            eret = 1'b0; epc_i = $urandom;
        end else begin
            step;
        end
        checks++; if (flags !== 6'b001111 || redirect_pc !== epc) begin errors++; $display("FAIL %s restore got=%b/%h exp=001111/%h", tag, flags, redirect_pc, epc); end

        step;
        checks++; if (flags !== 6'b000000 || irq_ack !== 8'h0) begin errors++; $display("FAIL %s idle_after got=%b exp=000000", tag, flags); end
        $display("svc %s pc=%h cause=%0d epc=%h early=%0d", tag, pc, cause_seen, epc, early);
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #2;
        checks++; if (flags !== 0 || pc_save !== 0 || redirect_pc !== 0 || InTcause !== 0 || irq_ack !== 0) begin
            errors++; $display("FAIL reset_outputs got=%b/%h/%h/%0d/%b exp=all zero", flags, pc_save, redirect_pc, InTcause, irq_ack);
        end
        step; step;
        rst = 1'b1;
        step;
        checks++; if (flags !== 0) begin errors++; $display("FAIL reset_release got=%b exp=000000", flags); end
        $display("reset done");
    endtask

    task automatic test_single;
        logic [4:0] c;
        irq = '0; int_en = 1'b1; step;
        irq = 8'b0000_0100; step;
        run_service("single", 32'h100, 32'h100, 8'h0, 1'b0, c);
        checks++; if (c !== 5'd18) begin errors++; $display("FAIL single_cause got=%0d exp=18", c); end
    endtask

    task automatic test_priority;
        logic [4:0] c;
        irq = '0; step;
        irq = 8'b0010_0010; step;
        run_service("prio1", 32'h300, 32'h304, 8'h0, 1'b0, c);
        checks++; if (c !== 5'd17) begin errors++; $display("FAIL prio_first got=%0d exp=17", c); end
        run_service("prio2", 32'h400, 32'h404, 8'h0, 1'b0, c);
        checks++; if (c !== 5'd21) begin errors++; $display("FAIL prio_second got=%0d exp=21", c); end
    endtask

    task automatic test_masked;
        logic [4:0] c;
        irq = '0; int_en = 1'b0; step;
        irq = 8'b0000_0001; step;
        for (int i = 0; i < 10; i++) begin
            instr_boundary = 1'b1; pc_i = $urandom;
            step;
            checks++; if (flags !== 0 || irq_ack !== 0) begin errors++; $display("FAIL masked_%0d got=%b/%b exp=000000/00000000", i, flags, irq_ack); end
        end
        instr_boundary = 1'b0;
        int_en = 1'b1;
        run_service("masked", 32'h500, 32'h500, 8'h0, 1'b0, c);
        checks++; if (c !== 5'd16) begin errors++; $display("FAIL masked_cause got=%0d exp=16", c); end
    endtask

    task automatic test_reedge;
        logic [4:0] c;
        irq = '0; int_en = 1'b1; step;
        irq = 8'b0000_1000; step;
        run_service("reedge1", 32'h600, 32'h600, 8'b0000_1000, 1'b0, c);
        checks++; if (c !== 5'd19) begin errors++; $display("FAIL reedge_first got=%0d exp=19", c); end
        run_service("reedge2", 32'h700, 32'h700, 8'h0, 1'b0, c);
        checks++; if (c !== 5'd19) begin errors++; $display("FAIL reedge_second got=%0d exp=19", c); end
    endtask

    task automatic test_reset_mid;
        irq = '0; int_en = 1'b1; step;
        irq = 8'b0100_0010; step;
        instr_boundary = 1'b1; pc_i = 32'h200; step;
        instr_boundary = 1'b0;
        step;
        checks++; if (pc_redirect !== 1'b1) begin errors++; $display("FAIL rstmid_vector got=%b exp=1", pc_redirect); end
        #1 rst = 1'b0; irq = '0;
        #1;
        checks++; if (flags !== 0 || pc_save !== 0 || redirect_pc !== 0 || InTcause !== 0 || irq_ack !== 0) begin
            errors++; $display("FAIL rstmid_outputs got=%b/%h/%h/%0d/%b exp=all zero", flags, pc_save, redirect_pc, InTcause, irq_ack);
        end
        step; step;
        rst = 1'b1;
        m_pend = '0; m_prev = '0; m_clr = '0;
        for (int i = 0; i < 5; i++) begin
            instr_boundary = 1'b1;
            step;
            checks++; if (flags !== 0 || irq_ack !== 0) begin errors++; $display("FAIL rstmid_after_%0d got=%b/%b exp=000000/00000000", i, flags, irq_ack); end
        end
        instr_boundary = 1'b0;
        $display("reset mid-sequence done");
    endtask

    task automatic test_random;
        logic [4:0] c;
        bit         early;
        for (int it = 0; it < 40; it++) begin
            irq = 8'($urandom);
            step;
            int_en = ($urandom_range(0, 3) != 0);
            if (int_en && m_pend != 0) begin
                early = ($urandom_range(0, 2) == 0);
                run_service($sformatf("rand%0d", it), $urandom, $urandom,
                            early ? 8'h0 : 8'(1 << $urandom_range(0, 7)), early, c);
            end else begin
                instr_boundary = 1'b1; pc_i = $urandom;
                step;
                instr_boundary = 1'b0;
                checks++; if (flags !== 0 || irq_ack !== 0) begin errors++; $display("FAIL rand%0d_noentry got=%b/%b exp=000000/00000000", it, flags, irq_ack); end
                $display("rand%0d no entry int_en=%0d pend=%b", it, int_en, m_pend);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_priority;
        test_masked;
        test_reedge;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
